// File: rtl/time_ascii_reporter_pkg.sv
// ---------------------------------------------------------------------------
// time_report_pkg
// Shared constants for the ASCII time reporter: bit positions of the fields
// in the packed 24-bit time bus, frame length, ASCII codes used in the frame
// and the FSM state type.
// ---------------------------------------------------------------------------
package time_report_pkg;

    // Packed time bus layout: hour[23:19] min[18:13] sec[12:7] msec[6:0]
    localparam int MSEC_LSB = 0;
    localparam int MSEC_W   = 7;
    localparam int SEC_LSB  = 7;
    localparam int SEC_W    = 6;
    localparam int MIN_LSB  = 13;
    localparam int MIN_W    = 6;
    localparam int HOUR_LSB = 19;
    localparam int HOUR_W   = 5;

    // "HH:MM:SS.CC" + CR + LF
    localparam int FRAME_LEN = 13;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // FSM encoding kept as plain vector constants for legacy tools
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SEND = 1'b1;

endpackage

// File: rtl/time_ascii_reporter_if.sv
// ---------------------------------------------------------------------------
// time_ascii_reporter_if
// Valid/ready byte stream from the reporter to the UART transmitter.
//   o_tx_data  : current ASCII byte (master -> slave)
//   o_tx_valid : o_tx_data is valid   (master -> slave)
//   i_tx_ready : sink accepts the byte on this edge (slave -> master)
// ---------------------------------------------------------------------------
interface time_ascii_reporter_if;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (output o_tx_data, output o_tx_valid, input i_tx_ready);
    modport slave  (input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/time_ascii_reporter_bin2ascii2.sv
// ---------------------------------------------------------------------------
// bin2ascii2
// Combinational two-digit decimal formatter.
//   value_i : 7-bit binary value (0..127)
//   tens_o  : ASCII tens digit, '?' when value_i > 99
//   ones_o  : ASCII ones digit, '?' when value_i > 99
// ---------------------------------------------------------------------------
module bin2ascii2
    import time_report_pkg::*;
(
    input  logic [6:0] value_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);

    logic [6:0] tens_v;
    logic [6:0] ones_v;

    always_comb begin
        tens_v = value_i / 7'd10;
        ones_v = value_i % 7'd10;
        if (value_i > 7'd99) begin
            tens_o = ASCII_QMARK;
            ones_o = ASCII_QMARK;
        end else begin
            tens_o = ASCII_ZERO + {1'b0, tens_v};
            ones_o = ASCII_ZERO + {1'b0, ones_v};
        end
    end

endmodule

// File: rtl/time_ascii_reporter.sv
// ---------------------------------------------------------------------------
// time_ascii_reporter
// Captures one snapshot of the packed time bus and streams it as the 13-byte
// frame "HH:MM:SS.CC\r\n" over a valid/ready byte interface. Frames start on
// i_req or automatically every AUTO_DIV ticks while i_auto is high.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   i_time  : packed time hour[23:19] min[18:13] sec[12:7] msec[6:0]
//   i_req   : single-cycle frame request
//   i_auto  : level, enables periodic requests
//   i_tick  : single-cycle 100 Hz tick
//   tx      : byte stream master (data/valid out, ready in)
//   o_busy  : a frame is in progress
// ---------------------------------------------------------------------------
module time_ascii_reporter
    import time_report_pkg::*;
#(
    parameter int AUTO_DIV = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [23:0]                  i_time,
    input  logic                         i_req,
    input  logic                         i_auto,
    input  logic                         i_tick,
    time_ascii_reporter_if.master        tx,
    output logic                         o_busy
);

    localparam int               CNT_W    = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_DIV - 1);
    localparam logic [3:0]       IDX_LAST = 4'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      snap_q, snap_d;

    logic             auto_req;
    logic             req;
    logic             xfer;
    logic [7:0]       byte_mux;

    logic [7:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o, msec_t, msec_o;

    // One formatter per field, all fed from the frozen snapshot
    bin2ascii2 u_hour (.value_i(7'(snap_q[HOUR_LSB +: HOUR_W])), .tens_o(hour_t), .ones_o(hour_o));
    bin2ascii2 u_min  (.value_i(7'(snap_q[MIN_LSB  +: MIN_W])),  .tens_o(min_t),  .ones_o(min_o));
    bin2ascii2 u_sec  (.value_i(7'(snap_q[SEC_LSB  +: SEC_W])),  .tens_o(sec_t),  .ones_o(sec_o));
    bin2ascii2 u_msec (.value_i(snap_q[MSEC_LSB +: MSEC_W]),     .tens_o(msec_t), .ones_o(msec_o));

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (a latch).
    always_comb begin
        auto_req  = 1'b0;
        cnt_d     = cnt_q;
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap_d    = snap_q;

        // Auto divider: the tick that hits the last count issues a request
        if (!i_auto) begin
            cnt_d = '0;
        end else if (i_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                auto_req = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // i_req and an auto request in the same cycle are one request
        req  = i_req | auto_req;
        xfer = (state_q == ST_SEND) && tx.i_tx_ready;

        if (state_q == ST_IDLE) begin
            if (req || pending_q) begin
                state_d   = ST_SEND;
                idx_d     = '0;
                pending_d = 1'b0;
                snap_d    = i_time;
            end
        end else begin
            // A request during the frame (including on its last transfer)
            // is remembered once; further ones are dropped.
            if (req) begin
                pending_d = 1'b1;
            end
            if (xfer) begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end
    end

    // Output byte is decoded from registers only; zero outside a frame
    always_comb begin
        byte_mux = 8'h00;
        if (state_q == ST_SEND) begin
            case (idx_q)
                4'd0:    byte_mux = hour_t;
                4'd1:    byte_mux = hour_o;
                4'd2:    byte_mux = ASCII_COLON;
                4'd3:    byte_mux = min_t;
                4'd4:    byte_mux = min_o;
                4'd5:    byte_mux = ASCII_COLON;
                4'd6:    byte_mux = sec_t;
                4'd7:    byte_mux = sec_o;
                4'd8:    byte_mux = ASCII_DOT;
                4'd9:    byte_mux = msec_t;
                4'd10:   byte_mux = msec_o;
                4'd11:   byte_mux = ASCII_CR;
                4'd12:   byte_mux = ASCII_LF;
                default: byte_mux = 8'h00;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            // NOTE: the snapshot is an ordinary register, not a memory array,
            // so it is reset like the rest and the output byte is defined.
            snap_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
        end
    end

    assign tx.o_tx_data  = byte_mux;
    assign tx.o_tx_valid = (state_q == ST_SEND);
    assign o_busy        = (state_q == ST_SEND);

endmodule

// File: doc/time_ascii_reporter.md
# time_ascii_reporter

Reads the packed 24-bit time bus driven by the watch/stopwatch mux and serializes one snapshot as a 13-byte ASCII frame `HH:MM:SS.CC` followed by CR LF. Bytes go out over a valid/ready byte stream into the UART transmitter. This makes the block the consumer of the time bus, at the opposite end from the datapaths that produce it. Frames start on an explicit request pulse or automatically every `AUTO_DIV` 100 Hz ticks.

## Interface
- `AUTO_DIV`, default 100: number of `i_tick` pulses between automatic requests (100 = 1 s).
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-low reset; one clock domain only.
- `i_time`  in  24  packed time: hour[23:19], min[18:13], sec[12:7], msec[6:0].
- `i_req`  in  1  single-cycle request to send one frame.
- `i_auto`  in  1  level; enables periodic requests.
- `i_tick`  in  1  single-cycle 100 Hz tick.
- `o_tx_data`  out  8  current ASCII byte.
- `o_tx_valid`  out  1  `o_tx_data` is valid.
- `i_tx_ready`  in  1  sink accepts the byte on this edge.
- `o_busy`  out  1  a frame is in progress.

## Operation
**Reset value:** all outputs are 0. FSM = IDLE, index = 0, pending = 0, auto counter = 0.

**FSM states**
- IDLE → SEND when a request is present: `i_req`, an auto request, or a pending request.
- SEND → IDLE after the byte at index 12 transfers.

**Snapshot**
- On IDLE→SEND, `i_time` is captured into an internal register.
- All 13 bytes of the frame come from that snapshot. Changes on `i_time` during the frame have no effect.

**Frame, index 0..12**
- Bytes: Ht Ho ':' Mt Mo ':' St So '.' Ct Co 0x0D 0x0A.
- Field value v maps to tens = v/10 and ones = v%10, each emitted as ASCII ('0' + d).
- If v > 99 (msec field only, max 127), both characters are '?' (0x3F).
- Hour is printed as its raw value (0..31). There is no range clamp.

**Handshake**
- A transfer happens when `o_tx_valid` and `i_tx_ready` are both 1 on a rising edge.
- While `o_tx_valid`=1 and no transfer occurs, `o_tx_data` is held stable.
- `o_tx_valid` never drops without a transfer, except on reset.

**Requests**
- Requests arriving while SEND is active set a 1-deep pending flag. Additional requests are dropped.
- Pending is cleared when it starts a frame.
- A request in the same cycle as the final-byte transfer counts as pending. It starts the next frame with no idle gap beyond 1 cycle.

**Auto mode**
- While `i_auto`=1, the counter increments on each `i_tick`.
- At the `i_tick` where the count equals `AUTO_DIV`-1, the block issues a request and the counter wraps to 0.
- `i_auto`=0 clears the counter.
- `i_req` and an auto request in the same cycle merge into one request.

**Other**
- `o_busy` = (state == SEND).
- Reset mid-frame aborts the frame immediately and asynchronously. Valid drops, and the partial frame is not resumed.

## Timing
**Latency**
- A request sampled at edge N moves the FSM to SEND and captures the snapshot at N.
- `o_tx_valid`=1 with byte 0 from the cycle after N.

**Throughput**
- With `i_tx_ready` held at 1, one byte is transferred per clock, so a frame takes 13 cycles.
- Byte k+1 is presented in the cycle after byte k transfers.

**Output timing**
- All outputs are registered or decoded from registers only.
- There is no combinational path from `i_tx_ready` to `o_tx_valid`.

## Structure
**Shared package `time_report_pkg`**
- Field LSB/width constants: MSEC 0/7, SEC 7/6, MIN 13/6, HOUR 19/5.
- `FRAME_LEN` = 13.
- ASCII constants: '0', ':', '.', '?', CR, LF.
- FSM state typedef.

**Sub-module `bin2ascii2`**
- Combinational: 7-bit value in, tens and ones ASCII characters out.
- Outputs '?' for values > 99.
- Four instances, one per field of the snapshot.

**Top level**
- Contains the FSM, index counter, pending flag, auto divider and output byte mux.

## Test plan
- Time 12:34:56.78 (hour=12, min=34, sec=56, msec=78), `i_req` pulse, ready=1 → bytes "12:34:56.78\r\n" on 13 consecutive cycles starting 1 cycle after the request; `o_busy` 1 for exactly 13 cycles.
- msec=100, all other fields 0, with ready toggling 1/0 → frame "00:00:00.??\r\n"; data stable while ready=0; no byte lost or duplicated.
- `i_time` changed every cycle mid-frame → emitted frame matches the snapshot taken at request acceptance.
- Three `i_req` pulses during one frame → exactly two frames total, the second starting within 1 cycle of the first's LF.
- `i_auto`=1, `AUTO_DIV`=4, ticks every 10 cycles → a frame starts after every 4th tick; deasserting `i_auto` and reasserting it restarts the count from 0.
- Reset asserted at byte 5 → `o_tx_valid`=0 immediately; after release, the next request produces a complete frame from byte 0.
